// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: takes pixels from the processing FIFO, writes them
// to the pixel BRAM and ping-pongs two frame banks on the reader's vsync.
//
//  state       | meaning
//  S_IDLE      | waiting for a start-of-frame pixel; other pixels are dropped
//  S_WRITE     | frame in progress, every accepted pixel is written
//  S_SWAP_WAIT | frame complete, input stalled until the reader's vsync rising edge
module fb_write_ctrl #(
    parameter int DW         = 12,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DOUBLE_BUF = 1,
    parameter int AW         = 20
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_sof,
    input  logic          i_rd_vsync,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_rd_bank,
    output logic          o_frame_done,
    output logic          o_err_short,
    output logic          o_err_long,
    output logic [7:0]    o_frame_cnt
);
    localparam int FRAME = H_ACTIVE * V_ACTIVE;
    localparam int PW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(FRAME - 1);
    localparam logic [AW-1:0] BANK_OFS = AW'(FRAME);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SWAP_WAIT} state_t;

    state_t        r_state;
    logic [PW-1:0] r_pix_idx;
    logic          r_wbank;
    logic          r_seen_frame;
    logic          r_rd_bank;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_frame_done;
    logic          r_err_short;
    logic          r_err_long;
    logic [7:0]    r_frame_cnt;
    logic          r_vs_meta;
    logic          r_vs_sync;
    logic          r_vs_prev;

    state_t        w_state_nxt;
    logic [PW-1:0] w_pix_nxt;
    logic [PW-1:0] w_wr_idx;
    logic          w_do_write;
    logic          w_wbank_nxt;
    logic          w_rd_bank_nxt;
    logic          w_seen_nxt;
    logic          w_err_short_nxt;
    logic          w_err_long_nxt;
    logic [7:0]    w_cnt_nxt;
    logic          w_done_nxt;
    logic          w_accept;
    logic          w_vs_rise;
    logic [AW-1:0] w_wr_addr;

    // Ready is also held low while reset is asserted so every output reads 0 then.
    assign o_data_ready = i_rstn && (r_state != S_SWAP_WAIT);
    assign w_accept     = i_data_valid && o_data_ready;
    assign w_vs_rise    = r_vs_sync && !r_vs_prev;
    assign w_wr_addr    = (r_wbank ? BANK_OFS : '0) + AW'(w_wr_idx);

    always_comb begin
        w_state_nxt     = r_state;
        w_pix_nxt       = r_pix_idx;
        w_wr_idx        = r_pix_idx;
        w_do_write      = 1'b0;
        w_wbank_nxt     = r_wbank;
        w_rd_bank_nxt   = r_rd_bank;
        w_seen_nxt      = r_seen_frame;
        w_err_short_nxt = r_err_short;
        w_err_long_nxt  = r_err_long;
        w_cnt_nxt       = r_frame_cnt;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept && i_sof) begin
                    w_do_write = 1'b1;
                    w_wr_idx   = '0;
                end else if (w_accept && r_seen_frame) begin
                    w_err_long_nxt = 1'b1;
                end
            end
            S_WRITE: begin
                if (w_accept) begin
                    w_do_write = 1'b1;
                    if (i_sof && (r_pix_idx != '0)) begin
                        w_err_short_nxt = 1'b1;
                        w_wr_idx        = '0;
                    end
                end
            end
            S_SWAP_WAIT: begin
                if (w_vs_rise && (DOUBLE_BUF != 0)) begin
                    w_rd_bank_nxt = r_wbank;
                    w_wbank_nxt   = !r_wbank;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_do_write) begin
            if (w_wr_idx == LAST_IDX) begin
                w_done_nxt  = 1'b1;
                w_cnt_nxt   = r_frame_cnt + 8'd1;
                w_seen_nxt  = 1'b1;
                w_pix_nxt   = '0;
                w_state_nxt = (DOUBLE_BUF != 0) ? S_SWAP_WAIT : S_IDLE;
            end else begin
                w_pix_nxt   = w_wr_idx + 1'b1;
                w_state_nxt = S_WRITE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_pix_idx    <= '0;
            r_wbank      <= 1'b0;
            r_seen_frame <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_vs_meta    <= 1'b0;
            r_vs_sync    <= 1'b0;
            r_vs_prev    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_idx    <= w_pix_nxt;
            r_wbank      <= w_wbank_nxt;
            r_seen_frame <= w_seen_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_wr_en      <= w_do_write;
            r_frame_done <= w_done_nxt;
            r_err_short  <= w_err_short_nxt;
            r_err_long   <= w_err_long_nxt;
            r_frame_cnt  <= w_cnt_nxt;
            r_vs_meta    <= i_rd_vsync;
            r_vs_sync    <= r_vs_meta;
            r_vs_prev    <= r_vs_sync;
            if (w_do_write) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= i_data;
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_rd_bank    = r_rd_bank;
    assign o_frame_done = r_frame_done;
    assign o_err_short  = r_err_short;
    assign o_err_long   = r_err_long;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Scoreboard bench for fb_write_ctrl: a double-buffered and a single-buffered
// instance on a 4x2 frame, selected one at a time by sel.
module tb_fb_write_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vs = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] data = '0;
    logic        sof = 1'b0;
    logic        sel = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v1, v0;
    logic        rdy1, rdy0, we1, we0, rb1, rb0, dn1, dn0, es1, es0, el1, el0;
    logic [7:0]  ad1, ad0, fc1, fc0;
    logic [11:0] wd1, wd0;
    assign v1 = valid && sel;
    assign v0 = valid && !sel;

    fb_write_ctrl #(.DW(12), .H_ACTIVE(4), .V_ACTIVE(2), .DOUBLE_BUF(1), .AW(8)) u_db1 (
        .i_clk(clk), .i_rstn(rstn), .i_data_valid(v1), .o_data_ready(rdy1),
        .i_data(data), .i_sof(sof), .i_rd_vsync(vs), .o_wr_en(we1),
        .o_wr_addr(ad1), .o_wr_data(wd1), .o_rd_bank(rb1), .o_frame_done(dn1),
        .o_err_short(es1), .o_err_long(el1), .o_frame_cnt(fc1));

    fb_write_ctrl #(.DW(12), .H_ACTIVE(4), .V_ACTIVE(2), .DOUBLE_BUF(0), .AW(8)) u_db0 (
        .i_clk(clk), .i_rstn(rstn), .i_data_valid(v0), .o_data_ready(rdy0),
        .i_data(data), .i_sof(sof), .i_rd_vsync(vs), .o_wr_en(we0),
        .o_wr_addr(ad0), .o_wr_data(wd0), .o_rd_bank(rb0), .o_frame_done(dn0),
        .o_err_short(es0), .o_err_long(el0), .o_frame_cnt(fc0));

    logic        m_rdy, m_we, m_rb, m_dn, m_es, m_el;
    logic [7:0]  m_ad, m_fc;
    logic [11:0] m_wd;
    always_comb begin
        m_rdy = sel ? rdy1 : rdy0;
        m_we  = sel ? we1  : we0;
        m_rb  = sel ? rb1  : rb0;
        m_dn  = sel ? dn1  : dn0;
        m_es  = sel ? es1  : es0;
        m_el  = sel ? el1  : el0;
        m_ad  = sel ? ad1  : ad0;
        m_fc  = sel ? fc1  : fc0;
        m_wd  = sel ? wd1  : wd0;
    end

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
        logic        last;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (m_we) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wr", m_ad, 8'hFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", m_ad, e.addr);
                    check("wr_data", m_wd, e.data);
                    check("wr_latency", cyc, e.cyc);
                    check("frame_done", m_dn, e.last);
                end
            end else if (m_dn) begin
                check("done_without_wr", m_dn, 1'b0);
            end
        end
    end

    // Present one pixel, hold it until accepted, and queue the write it must cause.
    task automatic send(input logic [11:0] d, input logic s, input logic exp_wr,
                        input logic [7:0] a, input logic last);
        int n = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        sof   = s;
        while (!m_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_rdy) begin
            check("ready_timeout", m_rdy, 1'b1);
        end else if (exp_wr) begin
            sb_q.push_back('{addr: a, data: d, last: last, cyc: cyc + 1});
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        vs = 1'b1;
        repeat (6) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] base, input logic [11:0] d0, input int gap_pct);
        for (int i = 0; i < 8; i++) begin
            while ($urandom_range(0, 99) < gap_pct) @(posedge clk);
            send(d0 + 12'(i), i == 0, 1'b1, base + 8'(i), i == 7);
        end
        drain();
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", m_rdy, 1'b0);
        check("rst_wr_en", m_we, 1'b0);
        check("rst_cnt", m_fc, 8'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", m_rdy, 1'b1);
        check("rd_bank_after_rst", m_rb, 1'b0);

        // full frame, swap stall, second frame into bank 1
        frame(8'd0, 12'h001, 0);
        check("cnt_frame1", m_fc, 8'd1);
        repeat (5) @(negedge clk);
        check("ready_swap_wait", m_rdy, 1'b0);
        check("rd_bank_before_vs", m_rb, 1'b0);
        pulse_vsync();
        check("ready_after_vs", m_rdy, 1'b1);
        check("rd_bank_swap1", m_rb, 1'b0);
        frame(8'd8, 12'h011, 0);
        check("cnt_frame2", m_fc, 8'd2);
        pulse_vsync();
        check("rd_bank_swap2", m_rb, 1'b1);
        frame(8'd0, 12'h021, 0);
        check("cnt_frame3", m_fc, 8'd3);
        check("no_err_long", m_el, 1'b0);

        // pixels before first SOF are dropped silently, then SOF restarts
        do_reset();
        for (int i = 0; i < 3; i++) send(12'h0B0 + 12'(i), 1'b0, 1'b0, 8'd0, 1'b0);
        drain();
        check("no_sof_err_long", m_el, 1'b0);
        check("no_sof_cnt", m_fc, 8'd0);
        send(12'h0A0, 1'b1, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i < 5; i++) send(12'h0A0 + 12'(i), 1'b0, 1'b1, 8'(i), 1'b0);
        drain();
        check("err_short_pre", m_es, 1'b0);

        // early SOF: error, frame restarts at address 0 of bank 0
        send(12'h0C0, 1'b1, 1'b1, 8'd0, 1'b0);
        drain();
        check("err_short_set", m_es, 1'b1);
        check("err_long_clear", m_el, 1'b0);

        // random valid gaps across the rest of this frame and the next one
        for (int i = 1; i < 8; i++) begin
            while ($urandom_range(0, 99) < 30) @(posedge clk);
            send(12'h0C0 + 12'(i), 1'b0, 1'b1, 8'(i), i == 7);
        end
        drain();
        check("cnt_after_restart", m_fc, 8'd1);
        pulse_vsync();
        frame(8'd8, 12'h0D0, 30);
        check("cnt_gap_frame", m_fc, 8'd2);
        check("err_short_sticky", m_es, 1'b1);

        // reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 5; i++) send(12'h0E0 + 12'(i), i == 0, 1'b1, 8'(i), 1'b0);
        drain();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_ready", m_rdy, 1'b0);
        check("midrst_wr_en", m_we, 1'b0);
        check("midrst_addr", m_ad, 8'd0);
        check("midrst_data", m_wd, 12'd0);
        check("midrst_done", m_dn, 1'b0);
        check("midrst_cnt", m_fc, 8'd0);
        check("midrst_err_short", m_es, 1'b0);
        check("midrst_rd_bank", m_rb, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        send(12'h0F0, 1'b1, 1'b1, 8'd0, 1'b0);
        drain();

        // single-buffered instance: two frames, then a late stray pixel
        sel = 1'b0;
        do_reset();
        frame(8'd0, 12'h101, 0);
        check("db0_rd_bank_f1", m_rb, 1'b0);
        check("db0_ready_f1", m_rdy, 1'b1);
        frame(8'd0, 12'h111, 0);
        check("db0_rd_bank_f2", m_rb, 1'b0);
        check("db0_cnt", m_fc, 8'd2);
        check("db0_err_long_pre", m_el, 1'b0);
        send(12'h1FF, 1'b0, 1'b0, 8'd0, 1'b0);
        drain();
        check("db0_err_long", m_el, 1'b1);
        check("db0_cnt_hold", m_fc, 8'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
